// File: rtl/link_pkg.sv
// Shared types and constant helpers for the symbol link sequencer.
// Holds the FSM state encoding plus the width and symbol-count derivations.
package link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TX    = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } link_state_e;

    function automatic int link_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Symbols per frame, rounded up so a partial last symbol still gets sent.
    function automatic int link_nsym(input int frame_w, input int sym_w);
        return (frame_w + sym_w - 1) / sym_w;
    endfunction

endpackage

// File: rtl/valid_delay.sv
// Fixed-depth delay line for a single valid bit, modelling channel latency.
// DEPTH=0 is a plain wire so the loopback can be combinational.
module valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    output logic valid_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign valid_o = valid_i;
        end else begin : g_pipe
            logic [DEPTH-1:0] sr_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr_q <= '0;
                end else begin
                    sr_q[0] <= valid_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        sr_q[i] <= sr_q[i-1];
                    end
                end
            end
            assign valid_o = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/symbol_link_sequencer.sv
// Serialises a coded frame into channel symbols, collects the returned symbols
// after the channel latency, and reports the reassembled frame and bit errors.
module symbol_link_sequencer
    import link_pkg::*;
#(
    parameter int FRAME_W = 28,
    parameter int SYM_W   = 2,
    parameter int CH_LAT  = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [FRAME_W-1:0]                  frame_i,
    input  logic [FRAME_W-1:0]                  err_mask,
    output logic [SYM_W-1:0]                    tx_sym,
    output logic                                tx_valid,
    input  logic [SYM_W-1:0]                    rx_sym,
    output logic                                busy,
    output logic                                done,
    output logic [FRAME_W-1:0]                  rx_frame,
    output logic [link_clog2(FRAME_W+1)-1:0]    err_cnt,
    output logic [1:0]                          dbg_state_o
);

    localparam int NSYM  = link_nsym(FRAME_W, SYM_W);
    localparam int PAD_W = NSYM * SYM_W;
    localparam int IDX_W = link_clog2(NSYM + 1);
    localparam int CNT_W = link_clog2(FRAME_W + 1);
    localparam logic [IDX_W-1:0] NSYM_IDX = IDX_W'(NSYM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);

    link_state_e        state_q;
    logic [PAD_W-1:0]   tx_buf_q;
    logic [FRAME_W-1:0] ref_buf_q;
    logic [PAD_W-1:0]   rx_buf_q;
    logic [PAD_W-1:0]   rx_buf_d;
    logic [IDX_W-1:0]   tx_idx_q;
    logic [IDX_W-1:0]   rx_idx_q;
    logic [SYM_W-1:0]   tx_sym_q;
    logic               tx_valid_q;
    logic               busy_q;
    logic               done_q;
    logic [FRAME_W-1:0] rx_frame_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic [CNT_W-1:0]   err_cnt_d;
    logic [FRAME_W-1:0] diff;
    logic               dl_out;
    logic               capture;
    logic               unused_rx_bits;

    valid_delay #(
        .DEPTH(CH_LAT)
    ) u_valid_delay (
        .clk    (clk),
        .rst_n  (rst),
        .valid_i(tx_valid_q),
        .valid_o(dl_out)
    );

    // Gating on the busy states keeps stray delay-line bits from landing in rx_buf.
    assign capture = dl_out && ((state_q == ST_TX) || (state_q == ST_DRAIN));

    always_comb begin
        rx_buf_d = rx_buf_q;
        if (capture) begin
            rx_buf_d[rx_idx_q*SYM_W +: SYM_W] = rx_sym;
        end
        diff = rx_buf_d[FRAME_W-1:0] ^ ref_buf_q;
        err_cnt_d = '0;
        for (int i = 0; i < FRAME_W; i++) begin
            err_cnt_d = err_cnt_d + CNT_W'(diff[i]);
        end
    end

    assign unused_rx_bits = ^rx_buf_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tx_buf_q   <= '0;
            ref_buf_q  <= '0;
            rx_buf_q   <= '0;
            tx_idx_q   <= '0;
            rx_idx_q   <= '0;
            tx_sym_q   <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_frame_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        tx_buf_q  <= PAD_W'(frame_i ^ err_mask);
                        ref_buf_q <= frame_i;
                        rx_buf_q  <= '0;
                        tx_idx_q  <= '0;
                        rx_idx_q  <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_TX;
                    end
                end
                ST_TX, ST_DRAIN: begin
                    if (state_q == ST_TX) begin
                        if (tx_idx_q != NSYM_IDX) begin
                            tx_sym_q   <= tx_buf_q[tx_idx_q*SYM_W +: SYM_W];
                            tx_valid_q <= 1'b1;
                            tx_idx_q   <= tx_idx_q + 1'b1;
                        end else begin
                            tx_sym_q   <= '0;
                            tx_valid_q <= 1'b0;
                            state_q    <= ST_DRAIN;
                        end
                    end
                    // With zero channel latency the last capture can land while still in TX.
                    if (capture) begin
                        rx_buf_q <= rx_buf_d;
                        rx_idx_q <= rx_idx_q + 1'b1;
                        if (rx_idx_q == LAST_IDX) begin
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            tx_sym_q   <= '0;
                            tx_valid_q <= 1'b0;
                            rx_frame_q <= rx_buf_d[FRAME_W-1:0];
                            err_cnt_q  <= err_cnt_d;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_sym      = tx_sym_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign rx_frame    = rx_frame_q;
    assign err_cnt     = err_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_symbol_link_sequencer.sv
// Bench for symbol_link_sequencer: three instances (QPSK/lat 3, 16-QAM padded/lat 0,
// BPSK/lat 2) with external loopbacks, a scoreboard of expected results and monitors.
module tb_symbol_link_sequencer;
    import link_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Instance A: FRAME_W=28, SYM_W=2, CH_LAT=3, three-register loopback
    logic        a_start = 1'b0;
    logic [27:0] a_frame = '0, a_mask = '0, a_rx_frame;
    logic [1:0]  a_tx_sym, a_rx_sym, a_state;
    logic        a_tx_valid, a_busy, a_done;
    logic [4:0]  a_err_cnt;
    logic [1:0]  a_l1 = '0, a_l2 = '0, a_l3 = '0;
    always @(posedge clk) begin
        a_l1 <= a_tx_sym;
        a_l2 <= a_l1;
        a_l3 <= a_l2;
    end
    assign a_rx_sym = a_l3;

    // Instance B: FRAME_W=30, SYM_W=4, CH_LAT=0, combinational loopback
    logic        b_start = 1'b0;
    logic [29:0] b_frame = '0, b_mask = '0, b_rx_frame;
    logic [3:0]  b_tx_sym, b_rx_sym;
    logic [1:0]  b_state;
    logic        b_tx_valid, b_busy, b_done;
    logic [4:0]  b_err_cnt;
    assign b_rx_sym = b_tx_sym;

    // Instance C: FRAME_W=8, SYM_W=1, CH_LAT=2, two-register loopback
    logic        c_start = 1'b0;
    logic [7:0]  c_frame = '0, c_mask = '0, c_rx_frame;
    logic        c_tx_sym, c_rx_sym;
    logic [1:0]  c_state;
    logic        c_tx_valid, c_busy, c_done;
    logic [3:0]  c_err_cnt;
    logic        c_l1 = 1'b0, c_l2 = 1'b0;
    always @(posedge clk) begin
        c_l1 <= c_tx_sym;
        c_l2 <= c_l1;
    end
    assign c_rx_sym = c_l2;

    symbol_link_sequencer #(.FRAME_W(28), .SYM_W(2), .CH_LAT(3)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .frame_i(a_frame), .err_mask(a_mask),
        .tx_sym(a_tx_sym), .tx_valid(a_tx_valid), .rx_sym(a_rx_sym), .busy(a_busy),
        .done(a_done), .rx_frame(a_rx_frame), .err_cnt(a_err_cnt), .dbg_state_o(a_state)
    );

    symbol_link_sequencer #(.FRAME_W(30), .SYM_W(4), .CH_LAT(0)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .frame_i(b_frame), .err_mask(b_mask),
        .tx_sym(b_tx_sym), .tx_valid(b_tx_valid), .rx_sym(b_rx_sym), .busy(b_busy),
        .done(b_done), .rx_frame(b_rx_frame), .err_cnt(b_err_cnt), .dbg_state_o(b_state)
    );

    symbol_link_sequencer #(.FRAME_W(8), .SYM_W(1), .CH_LAT(2)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .frame_i(c_frame), .err_mask(c_mask),
        .tx_sym(c_tx_sym), .tx_valid(c_tx_valid), .rx_sym(c_rx_sym), .busy(c_busy),
        .done(c_done), .rx_frame(c_rx_frame), .err_cnt(c_err_cnt), .dbg_state_o(c_state)
    );

    typedef struct {
        logic [63:0] frame;
        int          cnt;
        int          at;
    } exp_t;

    exp_t       a_q[$], b_q[$], c_q[$];
    exp_t       a_e, b_e, c_e, drop_e;
    logic [3:0] b_sym_q[$];
    logic       c_sym_q[$];
    logic [3:0] b_sym_e;
    logic       c_sym_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_line(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not expected or bound expired (t=%0t)", name, $time);
    endtask

    // Monitors: pop the scoreboard whenever a DUT presents done or a tx symbol.
    always @(negedge clk) begin
        if (rst) begin
            if (a_done) begin
                if (a_q.size() == 0) fail_line("a_unexpected_done");
                else begin
                    a_e = a_q.pop_front();
                    check("a_rx_frame", 64'(a_rx_frame), a_e.frame);
                    check("a_err_cnt", 64'(a_err_cnt), 64'(a_e.cnt));
                    check("a_done_cycle", 64'(cyc), 64'(a_e.at));
                end
            end
            if (!a_tx_valid) check("a_tx_sym_idle", 64'(a_tx_sym), 64'd0);

            if (b_done) begin
                if (b_q.size() == 0) fail_line("b_unexpected_done");
                else begin
                    b_e = b_q.pop_front();
                    check("b_rx_frame", 64'(b_rx_frame), b_e.frame);
                    check("b_err_cnt", 64'(b_err_cnt), 64'(b_e.cnt));
                    check("b_done_cycle", 64'(cyc), 64'(b_e.at));
                end
            end
            if (b_tx_valid) begin
                if (b_sym_q.size() == 0) fail_line("b_unexpected_tx");
                else begin
                    b_sym_e = b_sym_q.pop_front();
                    check("b_tx_sym", 64'(b_tx_sym), 64'(b_sym_e));
                end
            end

            if (c_done) begin
                if (c_q.size() == 0) fail_line("c_unexpected_done");
                else begin
                    c_e = c_q.pop_front();
                    check("c_rx_frame", 64'(c_rx_frame), c_e.frame);
                    check("c_err_cnt", 64'(c_err_cnt), 64'(c_e.cnt));
                    check("c_done_cycle", 64'(cyc), 64'(c_e.at));
                end
            end
            if (c_tx_valid) begin
                if (c_sym_q.size() == 0) fail_line("c_unexpected_tx");
                else begin
                    c_sym_e = c_sym_q.pop_front();
                    check("c_tx_sym", 64'(c_tx_sym), 64'(c_sym_e));
                end
            end
        end
    end

    // After each start pulse the frame inputs are scrambled to show they are not re-sampled.
    task automatic send_a(input logic [27:0] f, input logic [27:0] m,
                          input logic [27:0] exp_f, input int exp_cnt, input bit expect_done);
        @(negedge clk);
        a_frame = f;
        a_mask  = m;
        a_start = 1'b1;
        if (expect_done) a_q.push_back('{64'(exp_f), exp_cnt, cyc + 1 + 18});
        @(negedge clk);
        a_start = 1'b0;
        a_frame = 28'($urandom);
        a_mask  = 28'($urandom);
    endtask

    task automatic send_b(input logic [29:0] f, input logic [29:0] m, input logic [29:0] exp_f,
                          input int exp_cnt, input logic [31:0] exp_syms);
        @(negedge clk);
        b_frame = f;
        b_mask  = m;
        b_start = 1'b1;
        b_q.push_back('{64'(exp_f), exp_cnt, cyc + 1 + 9});
        for (int i = 0; i < 8; i++) b_sym_q.push_back(exp_syms[i*4 +: 4]);
        @(negedge clk);
        b_start = 1'b0;
        b_frame = 30'($urandom);
        b_mask  = 30'($urandom);
    endtask

    task automatic send_c(input logic [7:0] f, input logic [7:0] m, input logic [7:0] exp_f,
                          input int exp_cnt, input logic [7:0] exp_seq);
        @(negedge clk);
        c_frame = f;
        c_mask  = m;
        c_start = 1'b1;
        c_q.push_back('{64'(exp_f), exp_cnt, cyc + 1 + 11});
        for (int i = 0; i < 8; i++) c_sym_q.push_back(exp_seq[i]);
        @(negedge clk);
        c_start = 1'b0;
        c_frame = 8'($urandom);
        c_mask  = 8'($urandom);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((a_q.size() + b_q.size() + c_q.size() + b_sym_q.size() + c_sym_q.size()) != 0
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) fail_line("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_a_busy", 64'(a_busy), 64'd0);
        check("rst_a_done", 64'(a_done), 64'd0);
        check("rst_a_tx_valid", 64'(a_tx_valid), 64'd0);
        check("rst_a_rx_frame", 64'(a_rx_frame), 64'd0);
        check("rst_a_err_cnt", 64'(a_err_cnt), 64'd0);
        check("rst_a_state", 64'(a_state), 64'(ST_IDLE));
        check("rst_b_tx_sym", 64'(b_tx_sym), 64'd0);
        check("rst_c_busy", 64'(c_busy), 64'd0);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        // Clean loopback, then error injection, then a two-bit error
        send_a(28'h1234567, 28'h0000000, 28'h1234567, 0, 1'b1);
        @(negedge clk);
        check("a_busy_in_flight", 64'(a_busy), 64'd1);
        wait_drain(60);
        send_a(28'h1234567, 28'hF000000, 28'hE234567, 4, 1'b1);
        wait_drain(60);
        send_a(28'h7654321, 28'h0000011, 28'h7654330, 2, 1'b1);
        wait_drain(60);
        check("a_state_idle", 64'(a_state), 64'(ST_IDLE));

        // Second start 5 cycles after the first must be ignored
        send_a(28'h0ABCDEF, 28'h0000000, 28'h0ABCDEF, 0, 1'b1);
        repeat (3) @(negedge clk);
        send_a(28'h5555555, 28'h0000000, 28'h0000000, 0, 1'b0);
        wait_drain(60);
        repeat (30) @(negedge clk);
        check("a_hold_rx_frame", 64'(a_rx_frame), 64'h0ABCDEF);

        // Padded 16-QAM with combinational loopback
        send_b(30'h3FFFFFFF, 30'h00000000, 30'h3FFFFFFF, 0, 32'h3FFFFFFF);
        wait_drain(40);
        send_b(30'h3FFFFFFF, 30'h20000000, 30'h1FFFFFFF, 1, 32'h1FFFFFFF);
        wait_drain(40);

        // BPSK: expected tx sequence 1,0,1,0,0,1,0,1 (bit i = symbol i)
        send_c(8'hA5, 8'h00, 8'hA5, 0, 8'b1010_0101);
        wait_drain(40);
        send_c(8'h3C, 8'h81, 8'hBD, 2, 8'hBD);
        wait_drain(40);

        // Reset while draining: outputs clear, no done, next frame is clean
        send_a(28'h1111111, 28'h0000000, 28'h1111111, 0, 1'b1);
        n = 0;
        while (a_state != 2'(ST_DRAIN) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (a_state == 2'(ST_DRAIN)) begin
            #2 rst = 1'b0;
            drop_e = a_q.pop_back();
            #1;
            check("mid_rst_busy", 64'(a_busy), 64'd0);
            check("mid_rst_done", 64'(a_done), 64'd0);
            check("mid_rst_tx_valid", 64'(a_tx_valid), 64'd0);
            check("mid_rst_tx_sym", 64'(a_tx_sym), 64'd0);
            check("mid_rst_rx_frame", 64'(a_rx_frame), 64'd0);
            check("mid_rst_err_cnt", 64'(a_err_cnt), 64'd0);
            check("mid_rst_state", 64'(a_state), 64'(ST_IDLE));
        end else begin
            fail_line("a_reach_drain");
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (25) @(negedge clk);
        send_a(28'h2468ACE, 28'h0000003, 28'h2468ACD, 2, 1'b1);
        wait_drain(60);

        check("scoreboard_empty", 64'(a_q.size() + b_q.size() + c_q.size()
                                      + b_sym_q.size() + c_sym_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
